// File: rtl/insmem_server.sv
// Instruction-memory responder for the sequential Y86-64 core: byte-loadable
// storage that answers fetch requests with a 10-byte window after LAT cycles.
module insmem_server #(
  parameter int MEM_BYTES = 2048,
  parameter int LAT       = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ld_en_i,
  input  logic [$clog2(MEM_BYTES)-1:0] ld_addr_i,
  input  logic [7:0]                   ld_data_i,
  input  logic                         req_i,
  input  logic [63:0]                  req_addr_i,
  output logic                         busy_o,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [79:0]                  rsp_bytes_o,
  output logic                         imem_er_o
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] LastPc = 64'(MEM_BYTES - 10);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [63:0]  addr_q, addr_d;
  logic [79:0]  rsp_bytes_q, rsp_bytes_d;
  logic         imem_er_q, imem_er_d;
  logic [79:0]  win;
  logic         out_of_range;
  logic [7:0]   mem_q [MEM_BYTES];

  // Contents survive reset so a program loaded during reset stays in place.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  for (genvar k = 0; k < 10; k++) begin : g_win
    assign win[8*k +: 8] = mem_q[addr_q[AW-1:0] + AW'(k)];
  end

  assign out_of_range = (addr_q > LastPc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_i) state_d = WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    rsp_valid_o = (state_q == RESP);
  end

  always_comb begin
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rsp_bytes_d = rsp_bytes_q;
    imem_er_d   = imem_er_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d = req_addr_i;
          cnt_d  = 4'(LAT - 1);
        end
      end
      WAIT: begin
        // Capture reads the pre-edge memory, so a same-edge load is not seen.
        if (cnt_q == 4'd0) begin
          rsp_bytes_d = out_of_range ? 80'd0 : win;
          imem_er_d   = out_of_range;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= 4'd0;
      addr_q      <= 64'd0;
      rsp_bytes_q <= 80'd0;
      imem_er_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      rsp_bytes_q <= rsp_bytes_d;
      imem_er_q   <= imem_er_d;
    end
  end

  assign rsp_bytes_o = rsp_bytes_q;
  assign imem_er_o   = imem_er_q;

endmodule

// File: tb/tb_insmem_server.sv
// Scoreboard bench for insmem_server: a LAT=2/2048-byte instance for the main
// scenarios and a LAT=1/64-byte instance for back-to-back throughput.
module tb_insmem_server;

  localparam int MB  = 2048;
  localparam int MB1 = 64;

  typedef struct packed {
    logic [79:0] b;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_en;
  logic [10:0] ld_addr;
  logic [7:0]  ld_data;
  logic        req;
  logic [63:0] req_addr;
  logic        busy, rsp_valid, rsp_ready, imem_er;
  logic [79:0] rsp_bytes;

  logic        ld_en1;
  logic [5:0]  ld_addr1;
  logic [7:0]  ld_data1;
  logic        req1;
  logic [63:0] req_addr1;
  logic        busy1, rsp_valid1, rsp_ready1, imem_er1;
  logic [79:0] rsp_bytes1;

  logic [7:0]  mdl  [MB];
  logic [7:0]  mdl1 [MB1];
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  insmem_server #(.MEM_BYTES(MB), .LAT(2)) dut (
    .clk_i(clk), .rst_i(rst), .ld_en_i(ld_en), .ld_addr_i(ld_addr),
    .ld_data_i(ld_data), .req_i(req), .req_addr_i(req_addr), .busy_o(busy),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_bytes_o(rsp_bytes), .imem_er_o(imem_er)
  );

  insmem_server #(.MEM_BYTES(MB1), .LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .ld_en_i(ld_en1), .ld_addr_i(ld_addr1),
    .ld_data_i(ld_data1), .req_i(req1), .req_addr_i(req_addr1), .busy_o(busy1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1),
    .rsp_bytes_o(rsp_bytes1), .imem_er_o(imem_er1)
  );

  task automatic checkOutput(input string nm, input logic [79:0] act, input logic [79:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %h required %h", nm, act, expv);
  endtask

  function automatic exp_t mk0(input logic [63:0] pc);
    exp_t e;
    e.er = (pc > 64'(MB - 10));
    e.b  = '0;
    if (!e.er) for (int k = 0; k < 10; k++) e.b[8*k +: 8] = mdl[int'(pc[10:0]) + k];
    return e;
  endfunction

  function automatic exp_t mk1(input logic [63:0] pc);
    exp_t e;
    e.er = (pc > 64'(MB1 - 10));
    e.b  = '0;
    if (!e.er) for (int k = 0; k < 10; k++) e.b[8*k +: 8] = mdl1[int'(pc[5:0]) + k];
    return e;
  endfunction

  // Monitors pop one expectation per response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q0.size() == 0) begin
        checks++;
        $display("[TB] FAIL rsp0_unexpected: got response %h required none", rsp_bytes);
      end else begin
        e = q0.pop_front();
        checkOutput("rsp0_bytes", rsp_bytes, e.b);
        checkOutput("rsp0_er", 80'(imem_er), 80'(e.er));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        checks++;
        $display("[TB] FAIL rsp1_unexpected: got response %h required none", rsp_bytes1);
      end else begin
        e = q1.pop_front();
        checkOutput("rsp1_bytes", rsp_bytes1, e.b);
        checkOutput("rsp1_er", 80'(imem_er1), 80'(e.er));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Called at posedge+1 with busy low; returns at posedge+1 after the handshake.
  task automatic applyStimulus(input logic [63:0] pc);
    bit seen = 0;
    q0.push_back(mk0(pc));
    req = 1'b1;
    req_addr = pc;
    @(posedge clk); #1;
    req = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    if (!seen) begin
      checks++;
      $display("[TB] FAIL fetch_timeout: got no rsp_valid required response for pc %h", pc);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int nr, last, idx;
    bit prevB, seen;
    logic [63:0] addrs1 [4];

    for (int a = 0; a < MB; a++) mdl[a] = 8'(a * 7 + a / 256 + 1);
    mdl[0] = 8'h30; mdl[1] = 8'hF3; mdl[2] = 8'h0A;
    for (int a = 3; a < 10; a++) mdl[a] = 8'h00;
    mdl[16'h100] = 8'h10;
    for (int a = 0; a < MB1; a++) mdl1[a] = 8'(a * 13 + 5);

    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    req = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
    req1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 80'(busy), 80'd0);
    checkOutput("reset_valid", 80'(rsp_valid), 80'd0);
    checkOutput("reset_bytes", rsp_bytes, 80'd0);
    checkOutput("reset_er", 80'(imem_er), 80'd0);
    checkOutput("reset_valid1", 80'(rsp_valid1), 80'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    ld_en = 1'b1;
    for (int a = 0; a < MB; a++) begin
      ld_addr = 11'(a);
      ld_data = mdl[a];
      ld_en1 = (a < MB1);
      ld_addr1 = 6'(a);
      ld_data1 = mdl1[a % MB1];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
    ld_en1 = 1'b0;

    // First fetch with explicit latency checks.
    q0.push_back(mk0(64'd0));
    req = 1'b1; req_addr = 64'd0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    checkOutput("lat_busy_n0", 80'(busy), 80'd1);
    checkOutput("lat_valid_n0", 80'(rsp_valid), 80'd0);
    @(negedge clk);
    checkOutput("lat_valid_n1", 80'(rsp_valid), 80'd0);
    @(negedge clk);
    checkOutput("lat_valid_n2", 80'(rsp_valid), 80'd1);
    checkOutput("pc0_bytes", 80'(rsp_bytes[23:0]), 80'h0AF330);
    checkOutput("pc0_er", 80'(imem_er), 80'd0);
    @(negedge clk);
    checkOutput("post_hs_valid", 80'(rsp_valid), 80'd0);
    checkOutput("post_hs_busy", 80'(busy), 80'd0);
    checkOutput("post_hs_hold", 80'(rsp_bytes[23:0]), 80'h0AF330);
    @(posedge clk); #1;

    // Backpressure while a second request pulses.
    rsp_ready = 1'b0;
    q0.push_back(mk0(64'h40));
    req = 1'b1; req_addr = 64'h40;
    @(posedge clk); #1;
    req = 1'b0;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checkOutput("bp_valid_seen", 80'(seen), 80'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req = (i % 2 == 0);
      req_addr = 64'h20;
      @(negedge clk);
      checkOutput("bp_busy", 80'(busy), 80'd1);
      checkOutput("bp_valid", 80'(rsp_valid), 80'd1);
      checkOutput("bp_bytes", rsp_bytes, mk0(64'h40).b);
    end
    @(posedge clk); #1;
    req = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_ignored", 80'(rsp_valid), 80'd0);
    end
    @(posedge clk); #1;

    applyStimulus(64'd2038);
    applyStimulus(64'd2039);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFC);
    applyStimulus(64'h1_0000_0000);

    // Load to the fetched address on the capture edge.
    q0.push_back(mk0(64'h100));
    req = 1'b1; req_addr = 64'h100;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    ld_en = 1'b1; ld_addr = 11'h100; ld_data = 8'hAA;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mdl[16'h100] = 8'hAA;
    @(negedge clk);
    checkOutput("coll_valid", 80'(rsp_valid), 80'd1);
    checkOutput("coll_byte0", 80'(rsp_bytes[7:0]), 80'h10);
    @(posedge clk); #1;
    applyStimulus(64'h100);

    // Reset during WAIT drops the pending response.
    req = 1'b1; req_addr = 64'h30;
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstwait_valid", 80'(rsp_valid), 80'd0);
      checkOutput("rstwait_busy", 80'(busy), 80'd0);
    end
    checkOutput("rstwait_bytes", rsp_bytes, 80'd0);
    checkOutput("rstwait_er", 80'(imem_er), 80'd0);
    @(posedge clk); #1;
    applyStimulus(64'h30);

    // LAT=1 instance with req held high: one response every 3 cycles.
    addrs1[0] = 64'd0; addrs1[1] = 64'd5; addrs1[2] = 64'd54; addrs1[3] = 64'd55;
    q1.push_back(mk1(addrs1[0]));
    req_addr1 = addrs1[0];
    req1 = 1'b1;
    idx = 1; nr = 0; last = -1; prevB = 0;
    for (int t = 0; t < 40 && nr < 4; t++) begin
      @(negedge clk);
      if (rsp_valid1) begin
        if (last >= 0) checkOutput("lat1_spacing", 80'(cyc - last), 80'd3);
        last = cyc;
        nr++;
      end
      if (busy1 && !prevB) begin
        if (idx < 4) begin
          req_addr1 = addrs1[idx];
          q1.push_back(mk1(addrs1[idx]));
          idx++;
        end else begin
          req1 = 1'b0;
        end
      end
      prevB = busy1;
    end
    req1 = 1'b0;
    checkOutput("lat1_count", 80'(nr), 80'd4);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("q0_drained", 80'(q0.size()), 80'd0);
    checkOutput("q1_drained", 80'(q1.size()), 80'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
